// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART sender between N_REQ byte streams.
// Optional build macro ARB_TIMEOUT_EN: release a lock whose owner stalls for TIMEOUT_CYCLES cycles.
//
// state  | meaning
// IDLE   | no owner; scan req_valid starting at ptr and lock the first one found
// LOCKED | grant owns the sender until it delivers a byte flagged last
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ*8-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(N_REQ)-1:0] grant,
    output logic                     busy,
    output logic                     timeout
);
    localparam int GW = $clog2(N_REQ);
    localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] ptr, ptr_nxt;
    logic [GW-1:0] grant_nxt, grant_inc;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic          xfer;
    logic          tmo_hit;
    logic [7:0]    req_byte [N_REQ];

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_byte[i] = req_data[i*8 +: 8];
        end
    end

    // Scan from the far end back toward ptr so the closest valid index wins.
    always_comb begin
        logic [GW-1:0] j;
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = GW'((int'(ptr) + i) % N_REQ);
            if (req_valid[j]) begin
                pick_found = 1'b1;
                pick_idx   = j;
            end
        end
    end

    assign grant_inc = (grant == LAST_IDX) ? '0 : grant + GW'(1);
    assign busy      = (state == S_LOCKED);
    assign xfer      = busy && req_valid[grant] && out_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;

    // Counts down stalled owner cycles; any cycle with the owner valid reloads it.
    always_ff @(posedge clk) begin
        if (rst || !busy || req_valid[grant]) begin
            tmo_cnt <= TMO_LOAD;
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

    assign tmo_hit = busy && (tmo_cnt == '0) && !xfer;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            grant <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            grant <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        out_data  = '0;
        out_valid = 1'b0;
        req_ready = '0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                out_data         = req_byte[grant];
                out_valid        = req_valid[grant];
                req_ready[grant] = out_ready;
                if (xfer && req_last[grant]) begin
                    state_nxt = S_IDLE;
                    ptr_nxt   = grant_inc;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                    ptr_nxt   = grant_inc;
                    timeout   = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
